lf_cmd_ctrl: RTL and testbench
==============================

# lf_cmd_ctrl

Parametrised LF command/configuration controller. It replaces the free-running `posedge ncs` / `posedge spck` receiver with a single-clock, oversampled SPI frame receiver on `pck0`. It validates frame length, decodes commands into the conf/divisor/threshold registers, and sequences major-mode changes through a timed safe (all-off) interval. Its outputs drive `clk_divider`, the `lo_*` mode blocks and the `mux8` select lines.

## Interface
Parameters:
- `FRAME_W`, 16: bits per SPI frame; command field is the top `CMD_W` bits.
- `CMD_W`, 4: command field width.
- `CONF_W`, 9: conf register width; the mode field sits at `[CONF_W-1 -: MODE_W]`.
- `MODE_W`, 3: major-mode field width.
- `MODE_OFF`, 7: mode value presented while off or quiescing.
- `ED_MODE`, 1: mode code whose selection reloads the threshold.
- `SAFE_CYCLES`, 16: `pck0` cycles held in safe state on a mode change (≥1).
- `DIV_DEFAULT`, 95: divisor reset value.
- `ED_DEFAULT`, 127: threshold reset/reload value.

Ports:
- `pck0` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `spck` in 1: SPI clock, asynchronous; 2-FF synchronised internally.
- `mosi` in 1: SPI data, asynchronous; 2-FF synchronised.
- `ncs` in 1: SPI select, active low, asynchronous; 2-FF synchronised.
- `conf_word` out `CONF_W`: last accepted conf value.
- `divisor` out 8: clock divider value.
- `lf_ed_threshold` out 8: edge-detect threshold.
- `major_mode` out `MODE_W`: effective mode for the output muxes.
- `safe` out 1: high while quiescing; muxes force all outputs off.
- `cmd_valid` out 1: one-cycle pulse when a known command executes.
- `frame_err` out 1: one-cycle pulse when a frame is discarded for wrong length.

## Operation
- Commands: 1 = SET_CONFREG, 2 = SET_DIVISOR, 3 = SET_EDGE_DETECT_THRESHOLD. Any other code is discarded silently with no pulse.
- Synchronised `spck` rise, `ncs` fall and `ncs` rise each produce a single-cycle event pulse.
- Receiver FSM, IDLE → SHIFT → EXEC → IDLE:
  - IDLE: an `ncs` fall clears the bit counter and shift register and enters SHIFT.
  - SHIFT: on each `spck` rise, shift left and insert synchronised `mosi`. The counter saturates at `FRAME_W+1`.
  - SHIFT, `ncs` rise: if count == `FRAME_W`, go to EXEC. Otherwise pulse `frame_err` and return to IDLE with no register change.
  - EXEC (1 cycle): write the target register, pulse `cmd_valid`, return to IDLE.
- An `spck` rise while `ncs` is high is ignored.
- SET_CONFREG:
  - `conf_word` ← `data[CONF_W-1:0]`.
  - If the new mode field equals `ED_MODE`, `lf_ed_threshold` ← `ED_DEFAULT` in the same cycle.
  - If the new mode field ≠ `major_mode` and the mode FSM is in RUN, the mode FSM enters QUIESCE.
- SET_DIVISOR: `divisor` ← `data[7:0]`. SET_EDGE_DETECT_THRESHOLD: `lf_ed_threshold` ← `data[7:0]`.
- Mode FSM, RUN ↔ QUIESCE:
  - On entering QUIESCE: `safe`=1, `major_mode`=`MODE_OFF`, counter loaded with `SAFE_CYCLES-1`.
  - The counter decrements each cycle. At 0: `major_mode` ← target mode, `safe`=0, go to RUN.
  - A SET_CONFREG arriving during QUIESCE updates the target and reloads the counter (restart). This includes a write back to the pre-switch mode.
  - A SET_CONFREG with unchanged mode in RUN updates `conf_word` only; no safe interval.
- Reset, including mid-frame or mid-quiesce:
  - Receiver returns to IDLE and any partial frame is discarded.
  - Mode FSM goes to RUN.
  - `conf_word` = `MODE_OFF` in the mode field with other bits 0 (0x1C0 at defaults).
  - `divisor` = `DIV_DEFAULT`, `lf_ed_threshold` = `ED_DEFAULT`, `major_mode` = `MODE_OFF`.
  - `safe` = 0, `cmd_valid` = 0, `frame_err` = 0.
  - If `ncs` is low when reset releases, the receiver waits for the next `ncs` fall.

## Timing
- Input path: 2 sync FFs + 1 edge-detect FF. A pin transition produces its event pulse 3 `pck0` edges later; metastability adds up to +1.
- `spck` high and low phases must each be ≥3 `pck0` cycles. `mosi` must be stable ≥3 cycles around the `spck` rise; it is sampled on the same synchronised cycle as the event.
- `ncs` rise → `cmd_valid`/`frame_err` and register update: event pulse + 1 cycle (EXEC). All register writes and `cmd_valid` assert on the same edge.
- `safe` and `major_mode`=`MODE_OFF` assert on the same edge as the `conf_word` update.
- `safe` stays high for exactly `SAFE_CYCLES` cycles. The new `major_mode` appears on the edge where `safe` falls.
- Back-to-back frames are allowed with `ncs` high for ≥4 `pck0` cycles.

## Test plan
- Reset: all outputs at reset values (0x1C0, 95, 127, mode 7, `safe`=0, pulses 0). Send frame 0x1000 (mode 0) → `cmd_valid` pulse; `safe` high for 16 cycles with `major_mode`=7; then `major_mode`=0.
- Frame 0x2055 → `divisor`=0x55, `cmd_valid` one cycle, `safe` stays 0.
- Frame 0x3020, then frame 0x1040 (mode 1) → threshold 0x20, then reloaded to 127; `safe` 16 cycles; `major_mode`=1.
- 15-bit frame and 17-bit frame → `frame_err` pulse each; all registers and `cmd_valid` unchanged. Frame 0x5ABC → no pulses, no change.
- Mode 0 → frame 0x10C0 (mode 3); 5 cycles into QUIESCE send 0x1080 (mode 2) → counter restarts; `major_mode` goes 7 → 2 exactly 16 cycles after the second update; it is never 3.
- Assert `rst` mid-frame (8 bits shifted) and mid-quiesce → reset values next cycle. The next full frame 0x20AA → `divisor`=0xAA.

Source files
------------

// File: rtl/lf_cmd_ctrl_if.sv
// SPI pins from the host MCU into the LF command controller.
// All three lines are asynchronous to pck0; the receiver synchronises them.
interface lf_cmd_ctrl_if;
    logic spck;
    logic mosi;
    logic ncs;

    modport master (output spck, output mosi, output ncs);
    modport slave  (input  spck, input  mosi, input  ncs);
endinterface

// File: rtl/lf_cmd_ctrl.sv
// Oversampled SPI command receiver for the LF front end: decodes conf/divisor/threshold
// writes and walks every major-mode change through a timed all-off safe interval.
module lf_cmd_ctrl #(
    parameter int FRAME_W     = 16,
    parameter int CMD_W       = 4,
    parameter int CONF_W      = 9,
    parameter int MODE_W      = 3,
    parameter int MODE_OFF    = 7,
    parameter int ED_MODE     = 1,
    parameter int SAFE_CYCLES = 16,
    parameter int DIV_DEFAULT = 95,
    parameter int ED_DEFAULT  = 127
) (
    input  logic               pck0,
    input  logic               rst,
    lf_cmd_ctrl_if.slave       spi,
    output logic [CONF_W-1:0]  conf_word,
    output logic [7:0]         divisor,
    output logic [7:0]         lf_ed_threshold,
    output logic [MODE_W-1:0]  major_mode,
    output logic               safe,
    output logic               cmd_valid,
    output logic               frame_err
);

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_EXEC} rxState_t;
    typedef enum logic       {M_RUN, M_QUIESCE} modeState_t;

    localparam int BCW = $clog2(FRAME_W + 2);
    localparam int SCW = (SAFE_CYCLES > 1) ? $clog2(SAFE_CYCLES) : 1;
    localparam logic [CMD_W-1:0]  CMD_CONF = CMD_W'(1);
    localparam logic [CMD_W-1:0]  CMD_DIV  = CMD_W'(2);
    localparam logic [CMD_W-1:0]  CMD_THR  = CMD_W'(3);
    localparam logic [MODE_W-1:0] MODE_OFF_V = MODE_W'(MODE_OFF);
    localparam logic [CONF_W-1:0] CONF_RST = {MODE_OFF_V, (CONF_W - MODE_W)'(0)};

    logic [2:0] spckSync_q, ncsSync_q;
    logic [1:0] mosiSync_q;
    logic       spckRise, ncsFall, ncsRise, mosiBit;

    rxState_t           rxState_q, rxState_d;
    logic [BCW-1:0]     bitCnt_q, bitCnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CONF_W-1:0]  conf_q, conf_d;
    logic [7:0]         div_q, div_d, thr_q, thr_d;
    modeState_t         mState_q, mState_d;
    logic [SCW-1:0]     safeCnt_q, safeCnt_d;
    logic [MODE_W-1:0]  target_q, target_d, major_q, major_d;
    logic               safe_q, safe_d, cmdValid_q, cmdValid_d, frameErr_q, frameErr_d;

    logic [CMD_W-1:0]   cmdField;
    logic [MODE_W-1:0]  newMode;
    logic               unusedShiftBits;

    // Sync chain is left unreset so a low ncs at reset release never looks like a fall.
    always_ff @(posedge pck0) begin
        spckSync_q <= {spckSync_q[1:0], spi.spck};
        ncsSync_q  <= {ncsSync_q[1:0], spi.ncs};
        mosiSync_q <= {mosiSync_q[0], spi.mosi};
    end

    assign spckRise = spckSync_q[1] & ~spckSync_q[2];
    assign ncsFall  = ~ncsSync_q[1] & ncsSync_q[2];
    assign ncsRise  = ncsSync_q[1] & ~ncsSync_q[2];
    assign mosiBit  = mosiSync_q[1];

    assign cmdField        = shift_q[FRAME_W-1 -: CMD_W];
    assign newMode         = shift_q[CONF_W-1 -: MODE_W];
    assign unusedShiftBits = ^shift_q;

    always_comb begin
        rxState_d  = rxState_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        conf_d     = conf_q;
        div_d      = div_q;
        thr_d      = thr_q;
        mState_d   = mState_q;
        safeCnt_d  = safeCnt_q;
        target_d   = target_q;
        major_d    = major_q;
        safe_d     = safe_q;
        cmdValid_d = 1'b0;
        frameErr_d = 1'b0;

        case (rxState_q)
            RX_IDLE: begin
                if (ncsFall) begin
                    bitCnt_d  = '0;
                    shift_d   = '0;
                    rxState_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (ncsRise) begin
                    if (bitCnt_q == BCW'(FRAME_W)) begin
                        rxState_d = RX_EXEC;
                    end else begin
                        frameErr_d = 1'b1;
                        rxState_d  = RX_IDLE;
                    end
                end else if (spckRise) begin
                    shift_d = {shift_q[FRAME_W-2:0], mosiBit};
                    if (bitCnt_q != BCW'(FRAME_W + 1)) begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
            end
            RX_EXEC:  rxState_d = RX_IDLE;
            default:  rxState_d = RX_IDLE;
        endcase

        if (mState_q == M_QUIESCE) begin
            if (safeCnt_q == '0) begin
                major_d  = target_q;
                safe_d   = 1'b0;
                mState_d = M_RUN;
            end else begin
                safeCnt_d = safeCnt_q - 1'b1;
            end
        end

        // A conf write during quiesce always restarts the safe interval, even back to the old mode.
        if (rxState_q == RX_EXEC) begin
            case (cmdField)
                CMD_CONF: begin
                    cmdValid_d = 1'b1;
                    conf_d     = shift_q[CONF_W-1:0];
                    if (newMode == MODE_W'(ED_MODE)) begin
                        thr_d = 8'(ED_DEFAULT);
                    end
                    if (mState_q == M_QUIESCE || newMode != major_q) begin
                        mState_d  = M_QUIESCE;
                        safe_d    = 1'b1;
                        major_d   = MODE_OFF_V;
                        safeCnt_d = SCW'(SAFE_CYCLES - 1);
                        target_d  = newMode;
                    end
                end
                CMD_DIV: begin
                    cmdValid_d = 1'b1;
                    div_d      = shift_q[7:0];
                end
                CMD_THR: begin
                    cmdValid_d = 1'b1;
                    thr_d      = shift_q[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pck0) begin
        if (rst) begin
            rxState_q  <= RX_IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            conf_q     <= CONF_RST;
            div_q      <= 8'(DIV_DEFAULT);
            thr_q      <= 8'(ED_DEFAULT);
            mState_q   <= M_RUN;
            safeCnt_q  <= '0;
            target_q   <= MODE_OFF_V;
            major_q    <= MODE_OFF_V;
            safe_q     <= 1'b0;
            cmdValid_q <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            rxState_q  <= rxState_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            conf_q     <= conf_d;
            div_q      <= div_d;
            thr_q      <= thr_d;
            mState_q   <= mState_d;
            safeCnt_q  <= safeCnt_d;
            target_q   <= target_d;
            major_q    <= major_d;
            safe_q     <= safe_d;
            cmdValid_q <= cmdValid_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign conf_word       = conf_q;
    assign divisor         = div_q;
    assign lf_ed_threshold = thr_q;
    assign major_mode      = major_q;
    assign safe            = safe_q;
    assign cmd_valid       = cmdValid_q;
    assign frame_err       = frameErr_q;

endmodule

// File: tb/tb_lf_cmd_ctrl.sv
// Directed bench for lf_cmd_ctrl: bit-banged SPI frames with hand-computed expectations.
// The safe interval is lengthened so a second conf write can land inside an ongoing quiesce.
module tb_lf_cmd_ctrl;

    localparam int SAFE = 200;

    logic       pck0 = 1'b0;
    logic       rst;
    logic [8:0] conf_word;
    logic [7:0] divisor, lf_ed_threshold;
    logic [2:0] major_mode;
    logic       safe, cmd_valid, frame_err;

    int checks = 0;
    int failures = 0;

    int       cmdValidCount = 0, frameErrCount = 0, safeRises = 0;
    int       safeRun = 0, lastSafeLen = 0, cyclesSinceConf = 0, modeDelay = 0;
    logic     prevSafe = 1'b0, sawMode3 = 1'b0, badSafeMode = 1'b0;
    logic [8:0] prevConf = '0;
    logic [2:0] prevMajor = '0;

    lf_cmd_ctrl_if spi ();

    lf_cmd_ctrl #(.SAFE_CYCLES(SAFE)) dut (
        .pck0            (pck0),
        .rst             (rst),
        .spi             (spi),
        .conf_word       (conf_word),
        .divisor         (divisor),
        .lf_ed_threshold (lf_ed_threshold),
        .major_mode      (major_mode),
        .safe            (safe),
        .cmd_valid       (cmd_valid),
        .frame_err       (frame_err)
    );

    always #5 pck0 = ~pck0;

    // Observes pulses, safe-interval length and conf-to-mode latency on the falling edge.
    always @(negedge pck0) begin
        if (cmd_valid) cmdValidCount <= cmdValidCount + 1;
        if (frame_err) frameErrCount <= frameErrCount + 1;
        cyclesSinceConf <= (conf_word != prevConf) ? 0 : cyclesSinceConf + 1;
        if (major_mode != prevMajor && major_mode != 3'd7)
            modeDelay <= (conf_word != prevConf) ? 0 : cyclesSinceConf + 1;
        safeRun <= safe ? safeRun + 1 : 0;
        if (!safe && prevSafe) lastSafeLen <= safeRun;
        if (safe && !prevSafe) safeRises <= safeRises + 1;
        if (major_mode == 3'd3) sawMode3 <= 1'b1;
        if (safe && major_mode != 3'd7) badSafeMode <= 1'b1;
        prevSafe  <= safe;
        prevConf  <= conf_word;
        prevMajor <= major_mode;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge pck0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic shiftBits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi.mosi = val[i];
            waitCycles(4);
            spi.spck = 1'b1;
            waitCycles(4);
            spi.spck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] val, input int n);
        spi.ncs = 1'b0;
        waitCycles(4);
        shiftBits(val, n);
        waitCycles(4);
        spi.ncs = 1'b1;
        waitCycles(10);
    endtask

    initial begin
        rst      = 1'b1;
        spi.ncs  = 1'b1;
        spi.spck = 1'b0;
        spi.mosi = 1'b0;
        waitCycles(5);
        rst = 1'b0;
        waitCycles(2);

        checkOutput("rst_conf", conf_word, 32'h1C0);
        checkOutput("rst_div", divisor, 32'd95);
        checkOutput("rst_thr", lf_ed_threshold, 32'd127);
        checkOutput("rst_mode", major_mode, 32'd7);
        checkOutput("rst_safe", safe, 32'd0);
        checkOutput("rst_cmd_valid", cmd_valid, 32'd0);
        checkOutput("rst_frame_err", frame_err, 32'd0);

        applyStimulus(32'h1000, 16);
        checkOutput("m0_valid_cnt", cmdValidCount, 32'd1);
        checkOutput("m0_conf", conf_word, 32'h000);
        checkOutput("m0_safe_on", safe, 32'd1);
        checkOutput("m0_mode_off", major_mode, 32'd7);
        waitCycles(SAFE + 5);
        checkOutput("m0_mode", major_mode, 32'd0);
        checkOutput("m0_safe_off", safe, 32'd0);
        checkOutput("m0_safe_len", lastSafeLen, SAFE);
        checkOutput("m0_mode_delay", modeDelay, SAFE);
        checkOutput("m0_safe_mode", badSafeMode, 32'd0);

        applyStimulus(32'h2055, 16);
        checkOutput("div_val", divisor, 32'h55);
        checkOutput("div_valid_cnt", cmdValidCount, 32'd2);
        checkOutput("div_no_safe", safeRises, 32'd1);

        applyStimulus(32'h3020, 16);
        checkOutput("thr_val", lf_ed_threshold, 32'h20);
        applyStimulus(32'h1040, 16);
        checkOutput("ed_thr_reload", lf_ed_threshold, 32'd127);
        checkOutput("ed_conf", conf_word, 32'h040);
        waitCycles(SAFE + 5);
        checkOutput("ed_mode", major_mode, 32'd1);
        checkOutput("ed_safe_rises", safeRises, 32'd2);
        checkOutput("ed_safe_len", lastSafeLen, SAFE);
        checkOutput("ed_valid_cnt", cmdValidCount, 32'd4);

        applyStimulus(32'h2011, 15);
        checkOutput("short_err_cnt", frameErrCount, 32'd1);
        checkOutput("short_div", divisor, 32'h55);
        applyStimulus(32'h12011, 17);
        checkOutput("long_err_cnt", frameErrCount, 32'd2);
        checkOutput("long_div", divisor, 32'h55);
        applyStimulus(32'h5ABC, 16);
        checkOutput("unk_valid_cnt", cmdValidCount, 32'd4);
        checkOutput("unk_err_cnt", frameErrCount, 32'd2);
        checkOutput("unk_conf", conf_word, 32'h040);
        checkOutput("unk_thr", lf_ed_threshold, 32'd127);

        applyStimulus(32'h1000, 16);
        waitCycles(SAFE + 5);
        checkOutput("pre_restart_mode", major_mode, 32'd0);
        applyStimulus(32'h10C0, 16);
        checkOutput("restart_safe_on", safe, 32'd1);
        applyStimulus(32'h1080, 16);
        checkOutput("restart_still_safe", safe, 32'd1);
        waitCycles(SAFE + 10);
        checkOutput("restart_mode", major_mode, 32'd2);
        checkOutput("restart_delay", modeDelay, SAFE);
        checkOutput("restart_never3", sawMode3, 32'd0);
        checkOutput("restart_one_interval", safeRises, 32'd4);
        checkOutput("restart_conf", conf_word, 32'h080);
        checkOutput("restart_valid_cnt", cmdValidCount, 32'd7);

        applyStimulus(32'h1000, 16);
        checkOutput("mq_safe_on", safe, 32'd1);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("mq_rst_conf", conf_word, 32'h1C0);
        checkOutput("mq_rst_mode", major_mode, 32'd7);
        checkOutput("mq_rst_safe", safe, 32'd0);
        checkOutput("mq_rst_div", divisor, 32'd95);
        rst = 1'b0;
        waitCycles(2);

        spi.ncs = 1'b0;
        waitCycles(4);
        shiftBits(32'h20, 8);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("mf_rst_cmd_valid", cmd_valid, 32'd0);
        checkOutput("mf_rst_thr", lf_ed_threshold, 32'd127);
        rst = 1'b0;
        waitCycles(3);
        spi.ncs = 1'b1;
        waitCycles(10);
        checkOutput("mf_no_err", frameErrCount, 32'd2);
        checkOutput("mf_no_valid", cmdValidCount, 32'd8);
        applyStimulus(32'h20AA, 16);
        checkOutput("mf_div", divisor, 32'hAA);
        checkOutput("mf_valid_cnt", cmdValidCount, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
